// File: rtl/cflow_pkg.sv
// Shared control-flow log definitions: log capacity and reader state encoding.
// Imported by the log reader and by the log writer.
package cflow_pkg;

    localparam logic [15:0] LOG_SIZE_DEFAULT = 16'h0080;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT_WR = 3'd1,
        ST_RD      = 3'd2,
        ST_WT      = 3'd3,
        ST_SEND    = 3'd4,
        ST_FIN     = 3'd5
    } cflog_state_e;

    // Number of words to drain: the writer pointer, capped at the log capacity.
    function automatic logic [15:0] clamp_count(input logic [15:0] ptr, input logic [15:0] cap);
        return (ptr > cap) ? cap : ptr;
    endfunction

endpackage

// File: rtl/cflog_reader.sv
// Drains the control-flow log word by word over a valid/ready stream, then
// pulses done and log_clear so the writer can rewind its pointer.
module cflog_reader
    import cflow_pkg::*;
#(
    parameter logic [15:0] LOG_SIZE = LOG_SIZE_DEFAULT
) (
    input  logic        clk,
    input  logic        puc,
    input  logic        flush_req,
    input  logic [15:0] log_ptr,
    input  logic        hw_wen,
    output logic        mem_ren,
    output logic [15:0] mem_addr,
    input  logic [15:0] mem_rdata,
    output logic [15:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic        busy,
    output logic        done,
    output logic        log_clear
);

    cflog_state_e state_q, state_d;
    logic [15:0]  idx_q, idx_d;
    logic [15:0]  count_q, count_d;
    logic [15:0]  out_data_q, out_data_d;
    logic [15:0]  mem_addr_q, mem_addr_d;
    logic         mem_ren_q, mem_ren_d;
    logic         out_valid_q, out_valid_d;
    logic         out_last_q, out_last_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic         log_clear_q, log_clear_d;
    logic [15:0]  ptr_clamped;

    assign ptr_clamped = clamp_count(log_ptr, LOG_SIZE);

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        count_d    = count_q;
        out_data_d = out_data_q;

        case (state_q)
            ST_IDLE: begin
                if (flush_req) begin
                    if (hw_wen) begin
                        state_d = ST_WAIT_WR;
                    end else begin
                        count_d = ptr_clamped;
                        idx_d   = 16'd0;
                        state_d = (ptr_clamped == 16'd0) ? ST_FIN : ST_RD;
                    end
                end
            end
            ST_WAIT_WR: begin
                // Count is taken only once the writer has finished its last word.
                if (!hw_wen) begin
                    count_d = ptr_clamped;
                    idx_d   = 16'd0;
                    state_d = (ptr_clamped == 16'd0) ? ST_FIN : ST_RD;
                end
            end
            ST_RD: state_d = ST_WT;
            ST_WT: begin
                out_data_d = mem_rdata;
                state_d    = ST_SEND;
            end
            ST_SEND: begin
                if (out_ready) begin
                    if (idx_q == count_q - 16'd1) begin
                        state_d = ST_FIN;
                    end else begin
                        idx_d   = idx_q + 16'd1;
                        state_d = ST_RD;
                    end
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Outputs are decoded from the next state so they leave the flops aligned with it.
        mem_ren_d   = (state_d == ST_RD);
        mem_addr_d  = mem_ren_d ? idx_d : 16'd0;
        out_valid_d = (state_d == ST_SEND);
        out_last_d  = out_valid_d && (idx_d == count_d - 16'd1);
        busy_d      = (state_d != ST_IDLE);
        done_d      = (state_d == ST_FIN);
        log_clear_d = done_d;
    end

    always_ff @(posedge clk) begin
        if (puc) begin
            state_q     <= ST_IDLE;
            idx_q       <= 16'd0;
            count_q     <= 16'd0;
            out_data_q  <= 16'd0;
            mem_addr_q  <= 16'd0;
            mem_ren_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            log_clear_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            count_q     <= count_d;
            out_data_q  <= out_data_d;
            mem_addr_q  <= mem_addr_d;
            mem_ren_q   <= mem_ren_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            log_clear_q <= log_clear_d;
        end
    end

    assign mem_ren   = mem_ren_q;
    assign mem_addr  = mem_addr_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign log_clear = log_clear_q;

endmodule

// File: tb/tb_cflog_reader.sv
// Directed bench for cflog_reader: a registered-read log memory model plus
// scoreboard queues of expected addresses and words checked by a monitor.
module tb_cflog_reader;

    logic        clk = 1'b0;
    logic        puc, flush_req, hw_wen, out_ready;
    logic [15:0] log_ptr;
    logic [15:0] mem_rdata = 16'd0;
    logic        mem_ren, out_valid, out_last, busy, done, log_clear;
    logic [15:0] mem_addr, out_data;

    always #5 clk = ~clk;

    cflog_reader dut (
        .clk       (clk),
        .puc       (puc),
        .flush_req (flush_req),
        .log_ptr   (log_ptr),
        .hw_wen    (hw_wen),
        .mem_ren   (mem_ren),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done),
        .log_clear (log_clear)
    );

    logic [15:0] mem [0:511];
    always @(posedge clk) if (mem_ren) mem_rdata <= mem[mem_addr[8:0]];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int done_cnt = 0;
    int ren_cnt = 0;
    int last_hs_cyc = 0;
    logic [15:0] exp_addr_q[$];
    logic [15:0] exp_data_q[$];
    logic        exp_last_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: samples on the falling edge, pops scoreboard entries on each read and handshake.
    always @(negedge clk) begin
        if (puc !== 1'b1) begin
            if (mem_ren === 1'b1) begin
                ren_cnt++;
                tests++;
                if (exp_addr_q.size() == 0) begin
                    fails++;
                    $error("FAIL unexpected_ren: mem_addr=%h expected no read", mem_addr);
                end else begin
                    logic [15:0] ea;
                    ea = exp_addr_q.pop_front();
                    assert (mem_addr === ea) else begin
                        fails++;
                        $error("FAIL mem_addr: got %h expected %h", mem_addr, ea);
                    end
                end
            end else if (mem_addr !== 16'd0) begin
                tests++;
                fails++;
                $error("FAIL addr_idle: got %h expected 0000", mem_addr);
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                last_hs_cyc = cyc;
                tests++;
                if (exp_data_q.size() == 0) begin
                    fails++;
                    $error("FAIL unexpected_word: got %h expected no word", out_data);
                end else begin
                    logic [15:0] ed;
                    logic        el;
                    ed = exp_data_q.pop_front();
                    el = exp_last_q.pop_front();
                    assert (out_data === ed && out_last === el) else begin
                        fails++;
                        $error("FAIL word: got %h last=%b expected %h last=%b", out_data, out_last, ed, el);
                    end
                    $display("[TB] word %h last=%b", out_data, out_last);
                end
            end
            if (done === 1'b1) done_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push_drain(input int n);
        for (int i = 0; i < n; i++) begin
            exp_addr_q.push_back(16'(i));
            exp_data_q.push_back(mem[i]);
            exp_last_q.push_back(i == n - 1);
        end
    endtask

    task automatic wait_done(input int max, input string tag);
        int n;
        n = 0;
        while (done !== 1'b1 && n < max) begin
            tick();
            n++;
        end
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        check({tag, "_log_clear"}, {31'd0, log_clear}, 32'd1);
    endtask

    task automatic wait_valid(input int max, input string tag);
        int n;
        n = 0;
        while (out_valid !== 1'b1 && n < max) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    endtask

    task automatic pulse_flush();
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
    endtask

    initial begin
        int d0, r0;
        logic [15:0] held;
        puc = 1'b1; flush_req = 1'b0; hw_wen = 1'b0; out_ready = 1'b1; log_ptr = 16'd0;
        for (int i = 0; i < 512; i++) mem[i] = 16'h1000 + 16'(i * 3);
        mem[0] = 16'hA1A1; mem[1] = 16'hB2B2; mem[2] = 16'hC3C3;

        // Reset state
        tick(); tick();
        puc = 1'b0;
        check("reset_outs", {mem_ren, out_valid, out_last, busy, done, log_clear, 26'd0},
              32'd0);
        check("reset_data", {mem_addr, out_data}, 32'd0);

        // Three-word drain, done one cycle after final handshake
        log_ptr = 16'd3;
        push_drain(3);
        pulse_flush();
        check("busy_after_flush", {31'd0, busy}, 32'd1);
        wait_done(50, "drain3");
        check("done_after_last_hs", cyc, last_hs_cyc + 1);
        tick();
        check("done_one_cycle", {30'd0, done, log_clear}, 32'd0);
        check("drain3_q_empty", exp_data_q.size() + exp_addr_q.size(), 32'd0);

        // Empty log: straight to FIN
        log_ptr = 16'd0;
        d0 = done_cnt;
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        check("empty_fin", {29'd0, busy, done, out_valid}, 32'd6);
        tick();
        check("empty_idle", {30'd0, busy, done}, 32'd0);
        check("empty_done_cnt", done_cnt, d0 + 1);

        // Oversize pointer clamps to LOG_SIZE
        log_ptr = 16'h0200;
        push_drain(128);
        pulse_flush();
        wait_done(2000, "clamp");
        tick();
        check("clamp_q_empty", exp_data_q.size() + exp_addr_q.size(), 32'd0);

        // Flush while writer active waits; count sampled when hw_wen falls
        hw_wen = 1'b1;
        log_ptr = 16'd2;
        r0 = ren_cnt;
        pulse_flush();
        for (int i = 0; i < 3; i++) begin
            check("waitwr_busy_noren", {30'd0, busy, mem_ren}, 32'd2);
            tick();
        end
        log_ptr = 16'd5;
        push_drain(5);
        hw_wen = 1'b0;
        check("waitwr_no_ren_yet", ren_cnt, r0);
        wait_done(200, "waitwr");
        tick();
        check("waitwr_q_empty", exp_data_q.size(), 32'd0);

        // Back-pressure on word 1 plus ignored second flush
        log_ptr = 16'd4;
        out_ready = 1'b0;
        push_drain(4);
        d0 = done_cnt;
        pulse_flush();
        wait_valid(20, "bp_w0");
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        wait_valid(20, "bp_w1");
        held = out_data;
        check("bp_w1_data", {16'd0, held}, {16'd0, mem[1]});
        r0 = ren_cnt;
        flush_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            flush_req = 1'b0;
            check("bp_stable", {15'd0, out_valid, out_data}, {15'd0, 1'b1, held});
        end
        check("bp_no_extra_ren", ren_cnt, r0);
        out_ready = 1'b1;
        wait_done(100, "bp");
        for (int i = 0; i < 6; i++) tick();
        check("bp_single_done", done_cnt, d0 + 1);
        check("bp_idle", {31'd0, busy}, 32'd0);
        check("bp_q_empty", exp_data_q.size(), 32'd0);

        // Reset during SEND of word 1 of 4
        out_ready = 1'b0;
        push_drain(4);
        d0 = done_cnt;
        pulse_flush();
        wait_valid(20, "rst_w0");
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        wait_valid(20, "rst_w1");
        puc = 1'b1;
        tick();
        puc = 1'b0;
        exp_addr_q.delete(); exp_data_q.delete(); exp_last_q.delete();
        check("rst_mid_outs", {mem_ren, out_valid, out_last, busy, done, log_clear, 26'd0}, 32'd0);
        check("rst_mid_data", {mem_addr, out_data}, 32'd0);
        for (int i = 0; i < 8; i++) tick();
        check("rst_no_done", done_cnt, d0);

        // Reset and flush together: reset wins
        puc = 1'b1; flush_req = 1'b1;
        tick();
        puc = 1'b0; flush_req = 1'b0;
        tick();
        check("rst_flush_idle", {30'd0, busy, mem_ren}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
